// File: rtl/reg_file.sv
// reg_file: XLEN x NREGS integer register file with hardwired x0, two
// combinational read ports and same-cycle write-to-read bypass.
module reg_file #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data
);

  // Elaboration-time guard: the index width must cover NREGS exactly.
  if (NREGS != (32'd1 << ADDR_W)) begin : g_bad_params
    $error("reg_file: NREGS must equal 2**ADDR_W");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en_c;

  // A write only counts when enabled, out of reset and not aimed at x0.
  assign wr_en_c = reg_write && !rst && (rd_addr != ADDR_W'(0));

  // Register storage; slot 0 is cleared on reset and never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  // Read port 1: x0 and reset force zero, then bypass, then storage.
  always_comb begin
    rs1_data = '0;
    if (!rst && (rs1_addr != ADDR_W'(0))) begin
      if (reg_write && (rd_addr == rs1_addr)) begin
        rs1_data = rd_data;
      end else begin
        rs1_data = regs_q[rs1_addr];
      end
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data = '0;
    if (!rst && (rs2_addr != ADDR_W'(0))) begin
      if (reg_write && (rd_addr == rs2_addr)) begin
        rs2_data = rd_data;
      end else begin
        rs2_data = regs_q[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors; expected read data is queued by the
// stimulus and compared by an independent monitor process.
module tb_reg_file;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;

  typedef struct {
    string           name;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  logic [XLEN-1:0] alu_rd;

  reg_file #(.XLEN(XLEN), .NREGS(32), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .reg_write(reg_write),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each strobe pops one expectation and compares both read ports.
  always @(chk_ev) begin
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL monitor: strobe with empty expectation queue");
    end else begin
      e = q.pop_front();
      if (rs1_data !== e.e1 || rs2_data !== e.e2) begin
        errors++;
        $display("FAIL %s: rs1=%h rs2=%h expected rs1=%h rs2=%h",
                 e.name, rs1_data, rs2_data, e.e1, e.e2);
      end
    end
  end

  task automatic expect_rd(input string name, input logic [XLEN-1:0] e1,
                           input logic [XLEN-1:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    q.push_back(e);
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
  endtask

  // One write on the next rising edge, then the enable is dropped.
  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    reg_write = 1'b1;
    rd_addr   = a;
    rd_data   = d;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_rd(5'd5, 5'd31);
    expect_rd("reset_state", 64'h0, 64'h0);
    rst = 1'b0;

    // Reset clear, asynchronous and mid-cycle.
    write_reg(5'd5, 64'hDEAD_BEEF_0000_0001);
    set_rd(5'd5, 5'd0);
    expect_rd("x5_written", 64'hDEAD_BEEF_0000_0001, 64'h0);
    rst = 1'b1;
    expect_rd("async_reset_no_edge", 64'h0, 64'h0);
    reg_write = 1'b1; rd_addr = 5'd5; rd_data = 64'h1234;
    set_rd(5'd5, 5'd5);
    expect_rd("reset_blocks_bypass", 64'h0, 64'h0);
    @(posedge clk); #1;
    expect_rd("reset_blocks_write", 64'h0, 64'h0);
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(31 - i));
      expect_rd($sformatf("sweep_zero_%0d", i), 64'h0, 64'h0);
    end

    // Basic write/read.
    write_reg(5'd1, 64'h0000_0000_0000_000F);
    write_reg(5'd2, 64'h0000_0000_0000_0001);
    set_rd(5'd1, 5'd2);
    expect_rd("basic_rw", 64'hF, 64'h1);

    // x0 hardwire, with and without a matching write in flight.
    @(negedge clk);
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    set_rd(5'd0, 5'd0);
    expect_rd("x0_no_bypass", 64'h0, 64'h0);
    @(posedge clk); #1;
    reg_write = 1'b0;
    expect_rd("x0_stays_zero", 64'h0, 64'h0);

    // Bypass on both ports, then on one port only.
    write_reg(5'd7, 64'h5);
    set_rd(5'd7, 5'd7);
    expect_rd("x7_prior", 64'h5, 64'h5);
    @(negedge clk);
    reg_write = 1'b1; rd_addr = 5'd7; rd_data = 64'h7FFF_FFFF_FFFF_FFFF;
    expect_rd("bypass_both", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    set_rd(5'd7, 5'd1);
    expect_rd("bypass_one_port", 64'h7FFF_FFFF_FFFF_FFFF, 64'hF);
    @(posedge clk); #1;
    reg_write = 1'b0;
    set_rd(5'd7, 5'd7);
    expect_rd("bypass_stored", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);

    // Write-enable gating, including X on the write address/data.
    @(negedge clk);
    reg_write = 1'b0; rd_addr = 5'd3; rd_data = 64'hAAAA_AAAA_AAAA_AAAA;
    set_rd(5'd3, 5'd3);
    expect_rd("gate_no_bypass", 64'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    expect_rd("gate_no_write", 64'h0, 64'h0);
    rd_addr = 'x; rd_data = 'x;
    repeat (2) @(posedge clk);
    #1;
    set_rd(5'd1, 5'd3);
    expect_rd("x_safety", 64'hF, 64'h0);

    // Back-to-back writes to one index: last write wins.
    write_reg(5'd9, 64'h0000_0000_0000_00A0);
    write_reg(5'd9, 64'h0000_0000_0000_000B);
    set_rd(5'd9, 5'd9);
    expect_rd("last_write_wins", 64'hB, 64'hB);

    // Operand path into an arithmetic right shift (SRA), result written back.
    write_reg(5'd31, 64'h8000_0000_0000_0000);
    write_reg(5'd30, 64'h3F);
    set_rd(5'd31, 5'd30);
    expect_rd("alu_operands", 64'h8000_0000_0000_0000, 64'h3F);
    alu_rd = XLEN'($signed(rs1_data) >>> rs2_data[5:0]);
    write_reg(5'd29, alu_rd);
    set_rd(5'd29, 5'd29);
    expect_rd("alu_writeback", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Drain: every queued expectation must have been consumed.
    for (int i = 0; i < 10 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 64-bit RISC-V integer register file (x0..x31) sitting directly upstream of the ALU.
- Supplies the ALU's rs1/rs2 operands from two read ports.
- Accepts one writeback per cycle of the ALU result (rd) or another writeback source.
- x0 is hardwired to zero; same-cycle write-to-read bypass is provided so a result written this cycle is visible to a concurrent read.

Parameters:
- XLEN, 64, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register index width; must equal log2(NREGS).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears every register.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  XLEN  read port 1 data; drives ALU rs1.
- rs2_data  output  XLEN  read port 2 data; drives ALU rs2.
- reg_write  input  1  write enable for the writeback port.
- rd_addr  input  ADDR_W  write index.
- rd_data  input  XLEN  write data (ALU rd or other writeback source).

Behaviour:
- Storage: NREGS x XLEN flops, indexed 0..NREGS-1.
- Reset:
  - rst=1 asynchronously forces all registers to 0, independent of clk.
  - While rst=1, writes are ignored and rs1_data/rs2_data read 0 (bypass also suppressed).
  - On deassertion, the first possible write is the next rising clk edge with reg_write=1.
- Write: at rising clk, if rst=0 and reg_write=1 and rd_addr!=0, then reg[rd_addr] <= rd_data; takes effect the same edge.
- x0 rule:
  - Writes with rd_addr=0 are discarded; reg[0] is always 0.
  - Reads of index 0 always return 0, including when bypass would otherwise match.
- Reads are combinational (zero-cycle latency from address to data). Per port:
  - addr==0 -> 0.
  - Else if reg_write=1 and rd_addr==addr -> rd_data (bypass: write-before-read in the same cycle).
  - Else -> reg[addr].
- Both ports may read the same index simultaneously; both return identical data, including the bypassed value.
- Back-to-back writes to the same index on consecutive edges: the last write wins; no merging.
- reg_write=0: no state change regardless of rd_addr/rd_data.
- Values are stored and returned bit-exact as XLEN-wide patterns. No sign handling: signedness is the ALU's concern.
- X-safety: reg_write=0 with X on rd_addr/rd_data must not corrupt state.
- Implementation guidance: no latches. Use a single always block for writes with an asynchronous reset branch, and continuous assigns or a combinational block for read muxing.

Test Plan:
- Reset clear: write 64'hDEAD_BEEF_0000_0001 to x5, assert rst mid-cycle (between edges) -> rs1_data reads 0 for x5 immediately, before any clk edge; all 32 registers read 0 after rst deasserts.
- Basic write/read: write x1=64'h0000_0000_0000_000F and x2=64'h0000_0000_0000_0001 on successive edges; set rs1_addr=1, rs2_addr=2 -> rs1_data=000F, rs2_data=0001.
- x0 hardwire: reg_write=1, rd_addr=0, rd_data=64'hFFFF_FFFF_FFFF_FFFF, clock -> rs1_addr=0 reads 0. During that same cycle, with rs1_addr=0, rs1_data is still 0 (no bypass for x0).
- Bypass: x7 holds 64'h5; in one cycle drive reg_write=1, rd_addr=7, rd_data=64'h7FFF_FFFF_FFFF_FFFF, rs1_addr=rs2_addr=7 -> both outputs show 7FFF_FFFF_FFFF_FFFF before the edge; the stored value is the same after the edge.
- Write-enable gating: reg_write=0, rd_addr=3, rd_data=64'hAAAA_AAAA_AAAA_AAAA over 3 edges -> x3 remains at its prior value (0 after reset); no bypass shown on rs1 with rs1_addr=3.
- Full sweep with ALU: write x31=64'h8000_0000_0000_0000 and x30=64'h3F, then drive an instantiated ALU with func7=7'b0100000, func3=3'b101 from ports rs1=x31, rs2=x30 -> ALU rd=64'hFFFF_FFFF_FFFF_FFFF; write that back to x29 and read it back identical.
